// File: rtl/vc_rr_router_pkg.sv
// vc_rr_router_pkg: shared definitions for the virtual-channel router.
// Contents:
//   clog2     - constant log2, rounded up, used for field and counter widths
//   DEF_*     - default parameter values
//   VC_MSB    - bit position of the VC field for the default word width
//   DEST_MSB  - bit position of the destination field for the default word width
//   dest_msb  - destination field position for arbitrary word width / VC count
package vc_rr_router_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_DATA_W   = 6;
  localparam int DEF_NUM_VC   = 2;
  localparam int DEF_NUM_DEST = 2;
  localparam int DEF_VC_DEPTH = 16;

  localparam int VC_MSB   = DEF_DATA_W - 1;
  localparam int DEST_MSB = VC_MSB - clog2(DEF_NUM_VC);

  // The destination field sits directly below the VC field.
  function automatic int dest_msb(input int data_w, input int num_vc);
    return data_w - 1 - clog2(num_vc);
  endfunction

endpackage

// File: rtl/vc_rr_router_if.sv
// vc_rr_router_if: bundle of all router data/flow-control signals.
// Modports:
//   master - upstream/downstream environment (drives push_in, data_in,
//            thresholds, dest_pause; observes everything else)
//   slave  - the router itself
// Signals:
//   push_in, data_in        ingress word and strobe
//   vc_high_th, vc_low_th   in_pause hysteresis thresholds
//   dest_pause              per-destination back-pressure
//   push_dest, data_dest    registered per-destination output
//   in_pause                registered upstream pause
//   vc_empty, vc_error      per-VC status
//   idle                    nothing stored and nothing being pushed out
interface vc_rr_router_if
  import vc_rr_router_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_VC   = DEF_NUM_VC,
  parameter int NUM_DEST = DEF_NUM_DEST,
  parameter int VC_DEPTH = DEF_VC_DEPTH
) ();
  localparam int CNT_W = clog2(VC_DEPTH) + 1;

  logic                       push_in;
  logic [DATA_W-1:0]          data_in;
  logic [CNT_W-1:0]           vc_high_th;
  logic [CNT_W-1:0]           vc_low_th;
  logic [NUM_DEST-1:0]        dest_pause;
  logic [NUM_DEST-1:0]        push_dest;
  logic [NUM_DEST*DATA_W-1:0] data_dest;
  logic                       in_pause;
  logic [NUM_VC-1:0]          vc_empty;
  logic [NUM_VC-1:0]          vc_error;
  logic                       idle;

  modport master (
    output push_in, data_in, vc_high_th, vc_low_th, dest_pause,
    input  push_dest, data_dest, in_pause, vc_empty, vc_error, idle
  );

  modport slave (
    input  push_in, data_in, vc_high_th, vc_low_th, dest_pause,
    output push_dest, data_dest, in_pause, vc_empty, vc_error, idle
  );
endinterface

// File: rtl/vc_rr_router_vc_fifo.sv
// vc_fifo: first-word-fall-through FIFO holding one virtual channel.
// Ports:
//   clk, RESET_L  clock and synchronous active-low reset
//   push, din     write request and word
//   pop           remove head word (ignored when empty)
//   dout          head word, valid whenever count > 0
//   count         occupancy 0..DEPTH
//   full, empty   occupancy flags derived from count
module vc_fifo
  import vc_rr_router_pkg::*;
#(
  parameter int DEPTH  = DEF_VC_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    RESET_L,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr_en;
  logic              w_rd_en;

  assign w_rd_en = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle;
  // the write lands in the slot being vacated.
  assign w_wr_en = push && (!full || w_rd_en);

  // Storage has no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
endmodule

// File: rtl/vc_rr_router.sv
// vc_rr_router: sorts incoming words into NUM_VC virtual-channel FIFOs by
// their VC field and drains them to NUM_DEST destinations by their
// destination field, with one round-robin arbiter per destination.
// Ports:
//   clk      rising-edge clock
//   RESET_L  synchronous active-low reset
//   bus      router side of vc_rr_router_if (ingress word, thresholds,
//            dest_pause in; push_dest/data_dest, in_pause, status out)
module vc_rr_router
  import vc_rr_router_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_VC   = DEF_NUM_VC,
  parameter int NUM_DEST = DEF_NUM_DEST,
  parameter int VC_DEPTH = DEF_VC_DEPTH
) (
  input  logic           clk,
  input  logic           RESET_L,
  vc_rr_router_if.slave  bus
);
  localparam int VC_SEL_W   = clog2(NUM_VC);
  localparam int DEST_SEL_W = clog2(NUM_DEST);
  localparam int CNT_W      = clog2(VC_DEPTH) + 1;
  localparam int L_VC_MSB   = DATA_W - 1;
  localparam int L_DEST_MSB = dest_msb(DATA_W, NUM_VC);

  logic [VC_SEL_W-1:0]                 w_in_vc;
  logic [NUM_VC-1:0]                   w_push;
  logic [NUM_VC-1:0]                   w_pop;
  logic [NUM_VC-1:0]                   w_acc;
  logic [NUM_VC-1:0]                   w_full;
  logic [NUM_VC-1:0]                   w_empty;
  logic [NUM_VC-1:0][DATA_W-1:0]       w_dout;
  logic [NUM_VC-1:0][CNT_W-1:0]        w_count;
  logic [NUM_VC-1:0][CNT_W-1:0]        w_cnt_next;
  logic [NUM_VC-1:0][DEST_SEL_W-1:0]   w_head_dest;
  logic [NUM_DEST-1:0]                 w_gnt_vld;
  logic [NUM_DEST-1:0][VC_SEL_W-1:0]   w_gnt_idx;
  logic [NUM_DEST-1:0]                 w_push_dest;
  logic [NUM_DEST*DATA_W-1:0]          w_data_dest;
  logic                                w_any_high;
  logic                                w_all_low;
  logic                                r_in_pause;
  logic [NUM_VC-1:0]                   r_vc_error;

  assign w_in_vc = bus.data_in[L_VC_MSB -: VC_SEL_W];

  genvar gi;

  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign w_push[gi] = bus.push_in && (w_in_vc == VC_SEL_W'(gi));
      assign w_acc[gi]  = w_push[gi] && (!w_full[gi] || w_pop[gi]);
      // Post-update occupancy, used for the in_pause decision of this edge.
      assign w_cnt_next[gi] = w_count[gi] + CNT_W'(w_acc[gi]) - CNT_W'(w_pop[gi]);

      vc_fifo #(
        .DEPTH  (VC_DEPTH),
        .DATA_W (DATA_W)
      ) u_vc_fifo (
        .clk     (clk),
        .RESET_L (RESET_L),
        .push    (w_push[gi]),
        .pop     (w_pop[gi]),
        .din     (bus.data_in),
        .dout    (w_dout[gi]),
        .count   (w_count[gi]),
        .full    (w_full[gi]),
        .empty   (w_empty[gi])
      );

      assign w_head_dest[gi] = w_dout[gi][L_DEST_MSB -: DEST_SEL_W];
    end
  endgenerate

  // A VC head names a single destination, so at most one arbiter grants it.
  always_comb begin
    w_pop = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      if (w_gnt_vld[d]) begin
        w_pop[w_gnt_idx[d]] = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_DEST; gi++) begin : g_dest
      logic [VC_SEL_W-1:0] r_rr_ptr;
      logic                r_push;
      logic [DATA_W-1:0]   r_data;
      logic [NUM_VC-1:0]   w_cand;
      logic                w_vld;
      logic [VC_SEL_W-1:0] w_idx;

      always_comb begin
        w_cand = '0;
        for (int v = 0; v < NUM_VC; v++) begin
          w_cand[v] = !w_empty[v] && (w_head_dest[v] == DEST_SEL_W'(gi)) &&
                      !bus.dest_pause[gi];
        end
      end

      // Scan from the farthest offset down so the last hit kept is the one
      // closest to rr_ptr; the index arithmetic wraps modulo NUM_VC.
      always_comb begin
        w_vld = 1'b0;
        w_idx = '0;
        for (int off = NUM_VC - 1; off >= 0; off--) begin
          if (w_cand[r_rr_ptr + VC_SEL_W'(off)]) begin
            w_vld = 1'b1;
            w_idx = r_rr_ptr + VC_SEL_W'(off);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!RESET_L) begin
          r_rr_ptr <= '0;
          r_push   <= 1'b0;
          r_data   <= '0;
        end else begin
          r_push <= w_vld;
          if (w_vld) begin
            r_data   <= w_dout[w_idx];
            r_rr_ptr <= w_idx + VC_SEL_W'(1);
          end
        end
      end

      assign w_gnt_vld[gi]                       = w_vld;
      assign w_gnt_idx[gi]                       = w_idx;
      assign w_push_dest[gi]                     = r_push;
      assign w_data_dest[gi*DATA_W +: DATA_W]    = r_data;
    end
  endgenerate

  always_comb begin
    w_any_high = 1'b0;
    w_all_low  = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_cnt_next[v] >= bus.vc_high_th) begin
        w_any_high = 1'b1;
      end
      if (w_cnt_next[v] > bus.vc_low_th) begin
        w_all_low = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      r_in_pause <= 1'b0;
      r_vc_error <= '0;
    end else begin
      if (w_any_high) begin
        r_in_pause <= 1'b1;
      end else if (w_all_low) begin
        r_in_pause <= 1'b0;
      end
      // A word is lost only when its VC is full and nothing leaves this cycle.
      r_vc_error <= r_vc_error | (w_push & w_full & ~w_pop);
    end
  end

  assign bus.push_dest = w_push_dest;
  assign bus.data_dest = w_data_dest;
  assign bus.in_pause  = r_in_pause;
  assign bus.vc_empty  = w_empty;
  assign bus.vc_error  = r_vc_error;
  assign bus.idle      = (&w_empty) & ~(|w_push_dest);
endmodule
